// File: rtl/rgb_breath_seq_pkg.sv
// Shared types and palette for the RGB breathing colour sequencer.
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        BREATHE = 2'd0,
        BLINK   = 2'd1,
        STEADY  = 2'd2,
        HOLD    = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic [23:0] palette_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        unique case (idx)
            3'd0:    rgb = 24'hFF0000;  // red
            3'd1:    rgb = 24'hFF6100;  // orange
            3'd2:    rgb = 24'hFFFF00;  // yellow
            3'd3:    rgb = 24'h00FF00;  // green
            3'd4:    rgb = 24'h0000FF;  // blue
            3'd5:    rgb = 24'h7F1FFF;  // purple
            3'd6:    rgb = 24'h00FFFF;  // cyan
            default: rgb = 24'hFFFFFF;  // white
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/rgb_breath_seq_if.sv
// Control/status bundle between the button logic and the LED colour sequencer.
interface rgb_breath_seq_if
    import rgb_seq_pkg::*;
#(
    parameter int unsigned BRT_W = 5
);
    logic             tick;
    mode_e            mode;
    logic             pause;
    logic             skip;
    logic [23:0]      color;
    logic [BRT_W-1:0] brightness;
    logic [2:0]       color_idx;
    logic             cycle_done;

    modport master (
        output tick, mode, pause, skip,
        input  color, brightness, color_idx, cycle_done
    );

    modport slave (
        input  tick, mode, pause, skip,
        output color, brightness, color_idx, cycle_done
    );
endinterface

// File: rtl/rgb_breath_seq_brtns_gen.sv
// Brightness engine: step counter, level and ramp direction; requests a colour
// advance from the top when a breathe/blink/steady period completes.
module rgb_brtns_gen
    import rgb_seq_pkg::*;
#(
    parameter int unsigned BRT_W      = 5,
    parameter int unsigned STEP_CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             tick,
    input  logic             pause,
    input  logic             skip,
    input  mode_e            mode,
    output logic [BRT_W-1:0] brightness,
    output logic             advance
);
    localparam logic [BRT_W-1:0] BMAX    = '1;
    localparam logic [BRT_W-1:0] BRT_ONE = BRT_W'(1);

    logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
    logic [BRT_W-1:0]      brt_q, brt_d;
    dir_e                  dir_q, dir_d;
    mode_e                 mode_q, mode_d;
    logic                  mode_chg, step_en, step_done;

    always_comb begin
        cnt_d     = cnt_q;
        brt_d     = brt_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        advance   = 1'b0;
        // A mode change seen while paused stays pending until pause drops.
        mode_chg  = !pause && (mode != mode_q);
        step_en   = run && tick && !pause && !mode_chg && (mode_q != HOLD);
        step_done = step_en && (cnt_q == '1);
        if (!pause) mode_d = mode;

        if (skip) begin
            cnt_d = '0;
            dir_d = DIR_UP;
            brt_d = (mode_q == BREATHE || mode_q == BLINK) ? '0 : BMAX;
        end else if (run && !pause) begin
            if (mode_chg) begin
                cnt_d = '0;
                dir_d = DIR_UP;
            end else if (step_en) begin
                cnt_d = cnt_q + 1'b1;
            end

            unique case (mode_q)
                BREATHE: begin
                    if (step_done) begin
                        if (dir_q == DIR_UP) begin
                            if (brt_q == BMAX) begin
                                brt_d = BMAX - 1'b1;
                                dir_d = DIR_DOWN;
                            end else begin
                                brt_d = brt_q + 1'b1;
                            end
                        end else if (brt_q == '0) begin
                            brt_d   = BRT_ONE;
                            dir_d   = DIR_UP;
                            advance = 1'b1;
                        end else begin
                            brt_d = brt_q - 1'b1;
                        end
                    end
                end
                BLINK: begin
                    if (step_done) begin
                        if (brt_q != '0) begin
                            brt_d = '0;
                        end else begin
                            brt_d   = BMAX;
                            advance = 1'b1;
                        end
                    end
                end
                default: begin
                    brt_d   = BMAX;
                    advance = step_done;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            brt_q  <= '0;
            dir_q  <= DIR_UP;
            mode_q <= BREATHE;
        end else begin
            cnt_q  <= cnt_d;
            brt_q  <= brt_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
        end
    end

    assign brightness = brt_q;
endmodule

// File: rtl/rgb_breath_seq.sv
// RGB LED colour sequencer top: IDLE/RUN control, palette index, skip
// arbitration, cycle_done pulse and palette decode.
module rgb_breath_seq
    import rgb_seq_pkg::*;
#(
    parameter int unsigned BRT_W      = 5,
    parameter int unsigned STEP_CNT_W = 10,
    parameter int unsigned NUM_COLORS = 6
) (
    input logic             clk,
    input logic             rst,
    rgb_breath_seq_if.slave bus
);
    localparam logic [2:0] LAST_IDX = 3'(NUM_COLORS - 1);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             cdone_q, cdone_d;
    logic             run, skip_act, advance;
    logic [BRT_W-1:0] brt;

    assign run      = (state_q == RUN);
    assign skip_act = run && bus.skip;

    rgb_brtns_gen #(
        .BRT_W      (BRT_W),
        .STEP_CNT_W (STEP_CNT_W)
    ) u_brtns (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .tick       (bus.tick),
        .pause      (bus.pause),
        .skip       (skip_act),
        .mode       (bus.mode),
        .brightness (brt),
        .advance    (advance)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cdone_d = 1'b0;
        unique case (state_q)
            IDLE: if (bus.tick || bus.skip) state_d = RUN;
            default: begin
                // The engine suppresses its own advance under skip, so OR-ing
                // the two sources yields at most one step of the index.
                if (skip_act || advance) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        cdone_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cdone_q <= cdone_d;
        end
    end

    assign bus.color      = run ? palette_rgb(idx_q) : '0;
    assign bus.brightness = brt;
    assign bus.color_idx  = idx_q;
    assign bus.cycle_done = cdone_q;
endmodule
